// File: rtl/msm_naive.sv
// Naive sequential MSM engine, R = sum x[i]*G[i], with its curve package and affine point adder.
// Define MSM_LEADING_ZERO_SKIP_EN to skip leading-zero scalar bits (latency only).

package elliptic_curve_structs;
  localparam int unsigned P_WIDTH      = 16;
  localparam int unsigned SCALAR_WIDTH = 16;
  localparam logic [P_WIDTH-1:0] p = P_WIDTH'(65519);
  localparam logic [P_WIDTH-1:0] a = P_WIDTH'(2);
  localparam logic [P_WIDTH-1:0] b = P_WIDTH'(3);

  typedef struct packed {
    logic [P_WIDTH-1:0] x;
    logic [P_WIDTH-1:0] y;
  } curve_point_t;

  function automatic logic [P_WIDTH-1:0] mod_mul(input logic [P_WIDTH-1:0] u,
                                                 input logic [P_WIDTH-1:0] v);
    logic [2*P_WIDTH-1:0] t;
    t = ({{P_WIDTH{1'b0}}, u} * {{P_WIDTH{1'b0}}, v}) % {{P_WIDTH{1'b0}}, p};
    return t[P_WIDTH-1:0];
  endfunction

  function automatic logic [P_WIDTH-1:0] mod_add(input logic [P_WIDTH-1:0] u,
                                                 input logic [P_WIDTH-1:0] v);
    logic [P_WIDTH:0] s;
    s = {1'b0, u} + {1'b0, v};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return s[P_WIDTH-1:0];
  endfunction

  function automatic logic [P_WIDTH-1:0] mod_sub(input logic [P_WIDTH-1:0] u,
                                                 input logic [P_WIDTH-1:0] v);
    logic [P_WIDTH:0] s;
    s = {1'b0, u} + {1'b0, p} - {1'b0, v};
    if (s >= {1'b0, p}) s = s - {1'b0, p};
    return s[P_WIDTH-1:0];
  endfunction
endpackage

module ec_point_add
  import elliptic_curve_structs::*;
(
  input  logic         clk,
  input  logic         Reset,
  input  logic         i_start,
  input  logic         i_dbl,
  input  curve_point_t i_p,
  input  curve_point_t i_q,
  output logic         o_done,
  output curve_point_t o_r
);
  localparam int unsigned KW = $clog2(P_WIDTH);
  localparam logic [P_WIDTH-1:0] EXP = p - P_WIDTH'(2);

  typedef enum logic [2:0] {UIdle, UInv, ULam, UX3, UY3} ustate_t;

  ustate_t            r_state;
  logic [KW-1:0]      r_k;
  logic [P_WIDTH-1:0] r_x1, r_y1, r_x2, r_num, r_den, r_inv, r_lam, r_x3;
  curve_point_t       r_r;
  logic               r_done;
  logic [P_WIDTH-1:0] w_xx, w_sq, w_step;

  // Inversion by Fermat: den^(p-2), one square-and-multiply step per cycle, MSB first.
  assign w_xx   = mod_mul(i_p.x, i_p.x);
  assign w_sq   = mod_mul(r_inv, r_inv);
  assign w_step = EXP[r_k] ? mod_mul(w_sq, r_den) : w_sq;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= UIdle;
      r_k     <= '0;
      r_x1    <= '0;
      r_y1    <= '0;
      r_x2    <= '0;
      r_num   <= '0;
      r_den   <= '0;
      r_inv   <= '0;
      r_lam   <= '0;
      r_x3    <= '0;
      r_r     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        UIdle: begin
          if (i_start) begin
            r_x1 <= i_p.x;
            r_y1 <= i_p.y;
            r_x2 <= i_q.x;
            if (i_dbl) begin
              r_num <= mod_add(mod_add(w_xx, w_xx), mod_add(w_xx, a));
              r_den <= mod_add(i_p.y, i_p.y);
            end else begin
              r_num <= mod_sub(i_q.y, i_p.y);
              r_den <= mod_sub(i_q.x, i_p.x);
            end
            r_inv   <= P_WIDTH'(1);
            r_k     <= KW'(P_WIDTH - 1);
            r_state <= UInv;
          end
        end
        UInv: begin
          r_inv <= w_step;
          if (r_k == '0) r_state <= ULam;
          else r_k <= r_k - KW'(1);
        end
        ULam: begin
          r_lam   <= mod_mul(r_num, r_inv);
          r_state <= UX3;
        end
        UX3: begin
          r_x3    <= mod_sub(mod_sub(mod_mul(r_lam, r_lam), r_x1), r_x2);
          r_state <= UY3;
        end
        UY3: begin
          r_r.x   <= r_x3;
          r_r.y   <= mod_sub(mod_mul(r_lam, mod_sub(r_x1, r_x3)), r_y1);
          r_done  <= 1'b1;
          r_state <= UIdle;
        end
        default: r_state <= UIdle;
      endcase
    end
  end

  assign o_done = r_done;
  assign o_r    = r_r;
endmodule

module msm_naive
  import elliptic_curve_structs::*;
#(
  parameter int unsigned length = 100
) (
  input  logic                                clk,
  input  logic                                Reset,
  input  curve_point_t [length-1:0]           G,
  input  logic [length-1:0][SCALAR_WIDTH-1:0] x,
  output curve_point_t                        R,
  output logic                                Done
);
  localparam int unsigned IW = $clog2(length) + 1;
  localparam int unsigned JW = $clog2(SCALAR_WIDTH) + 1;

  typedef enum logic [3:0] {
    StInit, StPointStart, StDbl, StDblWait, StBitTest, StAdd, StAddWait,
    StNextBit, StAcc, StAccWait, StNextPoint, StDone
  } state_t;

  state_t                  r_state;
  logic [IW-1:0]           r_i;
  logic [JW-1:0]           r_j;
  curve_point_t            r_q, r_acc, r_r, r_op_a, r_op_b;
  logic                    r_done, r_start, r_dbl;
  curve_point_t            w_g, w_op_a, w_op_b, w_triv_res, w_unit_res;
  logic [SCALAR_WIDTH-1:0] w_xi, w_shift;
  logic                    w_bit, w_triv, w_use_dbl, w_unit_done;

  always_comb begin
    w_g  = '0;
    w_xi = '0;
    for (int unsigned k = 0; k < length; k++) begin
      if (r_i == IW'(k)) begin
        w_g  = G[k];
        w_xi = x[k];
      end
    end
  end

  assign w_shift = w_xi >> r_j;
  assign w_bit   = w_shift[0];

`ifdef MSM_LEADING_ZERO_SKIP_EN
  logic [JW-1:0] w_msb;
  always_comb begin
    w_msb = '0;
    for (int unsigned k = 0; k < SCALAR_WIDTH; k++) begin
      if (w_xi[k]) w_msb = JW'(k);
    end
  end
`endif

  always_comb begin
    w_op_a = r_q;
    w_op_b = r_q;
    if (r_state == StAdd) begin
      w_op_b = w_g;
    end else if (r_state == StAcc) begin
      w_op_a = r_acc;
    end
  end

  // Special cases resolved here; only genuine add/double reaches the shared unit.
  always_comb begin
    w_triv     = 1'b0;
    w_triv_res = '0;
    w_use_dbl  = 1'b0;
    if (w_op_a == '0) begin
      w_triv     = 1'b1;
      w_triv_res = w_op_b;
    end else if (w_op_b == '0) begin
      w_triv     = 1'b1;
      w_triv_res = w_op_a;
    end else if (w_op_a.x == w_op_b.x) begin
      if (w_op_a.y == w_op_b.y && w_op_a.y != '0) w_use_dbl = 1'b1;
      else w_triv = 1'b1;
    end
  end

  ec_point_add u_add (
    .clk     (clk),
    .Reset   (Reset),
    .i_start (r_start),
    .i_dbl   (r_dbl),
    .i_p     (r_op_a),
    .i_q     (r_op_b),
    .o_done  (w_unit_done),
    .o_r     (w_unit_res)
  );

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state <= StInit;
      r_i     <= '0;
      r_j     <= '0;
      r_q     <= '0;
      r_acc   <= '0;
      r_r     <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_done  <= 1'b0;
      r_start <= 1'b0;
      r_dbl   <= 1'b0;
    end else begin
      r_start <= 1'b0;
      unique case (r_state)
        StInit: begin
          r_acc   <= '0;
          r_i     <= '0;
          r_state <= StPointStart;
        end
        StPointStart: begin
          r_q <= '0;
`ifdef MSM_LEADING_ZERO_SKIP_EN
          if (w_xi == '0) begin
            r_state <= StNextPoint;
          end else begin
            r_j     <= w_msb;
            r_state <= StDbl;
          end
`else
          r_j     <= JW'(SCALAR_WIDTH - 1);
          r_state <= StDbl;
`endif
        end
        StDbl, StAdd, StAcc: begin
          if (w_triv) begin
            if (r_state == StAcc) r_acc <= w_triv_res;
            else r_q <= w_triv_res;
            r_state <= (r_state == StDbl) ? StBitTest :
                       (r_state == StAdd) ? StNextBit : StNextPoint;
          end else begin
            r_op_a  <= w_op_a;
            r_op_b  <= w_op_b;
            r_dbl   <= w_use_dbl;
            r_start <= 1'b1;
            r_state <= (r_state == StDbl) ? StDblWait :
                       (r_state == StAdd) ? StAddWait : StAccWait;
          end
        end
        StDblWait: begin
          if (w_unit_done) begin
            r_q     <= w_unit_res;
            r_state <= StBitTest;
          end
        end
        StBitTest: r_state <= w_bit ? StAdd : StNextBit;
        StAddWait: begin
          if (w_unit_done) begin
            r_q     <= w_unit_res;
            r_state <= StNextBit;
          end
        end
        StNextBit: begin
          if (r_j == '0) begin
            r_state <= StAcc;
          end else begin
            r_j     <= r_j - JW'(1);
            r_state <= StDbl;
          end
        end
        StAccWait: begin
          if (w_unit_done) begin
            r_acc   <= w_unit_res;
            r_state <= StNextPoint;
          end
        end
        StNextPoint: begin
          r_i <= r_i + IW'(1);
          if (r_i + IW'(1) == IW'(length)) begin
            r_r     <= r_acc;
            r_done  <= 1'b1;
            r_state <= StDone;
          end else begin
            r_state <= StPointStart;
          end
        end
        StDone: r_state <= StDone;
        default: r_state <= StInit;
      endcase
    end
  end

  assign R    = r_r;
  assign Done = r_done;
endmodule

// File: tb/tb_msm_naive.sv
// Bench for msm_naive: three instances (length 1, 2, 8) against an arithmetic curve model.
module tb_msm_naive;
  import elliptic_curve_structs::*;

  localparam longint unsigned PM = 64'(p);
  localparam longint unsigned AM = 64'(a);
  localparam longint unsigned BM = 64'(b);
  localparam int unsigned BUDGET = 30000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  curve_point_t [0:0]                     g1;
  logic [0:0][SCALAR_WIDTH-1:0]           x1;
  curve_point_t [1:0]                     g2;
  logic [1:0][SCALAR_WIDTH-1:0]           x2;
  curve_point_t [7:0]                     g8;
  logic [7:0][SCALAR_WIDTH-1:0]           x8;
  curve_point_t                           r1, r2, r8;
  logic                                   done1, done2, done8;
  curve_point_t                           gen, pt, qt, e1, e2, e8;
  int                                     n_checks = 0;
  int                                     n_fail = 0;

  msm_naive #(.length(1)) d1 (.clk(clk), .Reset(rst), .G(g1), .x(x1), .R(r1), .Done(done1));
  msm_naive #(.length(2)) d2 (.clk(clk), .Reset(rst), .G(g2), .x(x2), .R(r2), .Done(done2));
  msm_naive #(.length(8)) d8 (.clk(clk), .Reset(rst), .G(g8), .x(x8), .R(r8), .Done(done8));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned mm(longint unsigned u, longint unsigned v);
    return (u * v) % PM;
  endfunction

  function automatic longint unsigned mpow(longint unsigned bse, longint unsigned e);
    longint unsigned r = 1;
    longint unsigned bb = bse % PM;
    longint unsigned ee = e;
    while (ee > 0) begin
      if (ee[0]) r = mm(r, bb);
      bb = mm(bb, bb);
      ee = ee >> 1;
    end
    return r;
  endfunction

  function automatic curve_point_t mk(longint unsigned px, longint unsigned py);
    curve_point_t t;
    t.x = px[P_WIDTH-1:0];
    t.y = py[P_WIDTH-1:0];
    return t;
  endfunction

  // Textbook affine group law on the curve.
  function automatic curve_point_t padd(curve_point_t s, curve_point_t t);
    longint unsigned sx = 64'(s.x), sy = 64'(s.y), tx = 64'(t.x), ty = 64'(t.y);
    longint unsigned lam, x3, y3;
    if (s == '0) return t;
    if (t == '0) return s;
    if (sx == tx) begin
      if ((sy + ty) % PM == 0) return '0;
      lam = mm((3 * mm(sx, sx) + AM) % PM, mpow((2 * sy) % PM, PM - 2));
    end else begin
      lam = mm((ty + PM - sy) % PM, mpow((tx + PM - sx) % PM, PM - 2));
    end
    x3 = (mm(lam, lam) + 2 * PM - sx - tx) % PM;
    y3 = (mm(lam, (sx + PM - x3) % PM) + PM - sy) % PM;
    return mk(x3, y3);
  endfunction

  function automatic curve_point_t smul(longint unsigned k, curve_point_t pp);
    curve_point_t acc = '0;
    curve_point_t base = pp;
    longint unsigned kk = k;
    while (kk > 0) begin
      if (kk[0]) acc = padd(acc, base);
      base = padd(base, base);
      kk = kk >> 1;
    end
    return acc;
  endfunction

  function automatic curve_point_t model8(curve_point_t [7:0] gg, logic [7:0][SCALAR_WIDTH-1:0] xx);
    curve_point_t acc = '0;
    for (int k = 0; k < 8; k++) acc = padd(acc, smul(64'(xx[k]), gg[k]));
    return acc;
  endfunction

  function automatic curve_point_t rand_point();
    longint unsigned px, rhs, py;
    for (int n = 0; n < 2000; n++) begin
      px  = 64'($urandom_range(1, 32'(PM - 1)));
      rhs = (mm(mm(px, px), px) + mm(AM, px) + BM) % PM;
      py  = mpow(rhs, (PM + 1) / 4);
      if (py != 0 && mm(py, py) == rhs) return mk(px, py);
    end
    return '0;
  endfunction

  function automatic curve_point_t neg(curve_point_t s);
    return mk(64'(s.x), (PM - 64'(s.y)) % PM);
  endfunction

  task automatic fill8_random();
    for (int k = 0; k < 8; k++) begin
      g8[k] = rand_point();
      x8[k] = SCALAR_WIDTH'($urandom);
    end
  endtask

  task automatic wait_all(input string tag);
    int unsigned c = 0;
    while (!(done1 && done2 && done8) && c < BUDGET) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_in_time"}, 64'(c < BUDGET), 64'd1);
  endtask

  task automatic check_results(input string tag);
    check({tag, "_done1"}, 64'(done1), 64'd1);
    check({tag, "_done2"}, 64'(done2), 64'd1);
    check({tag, "_done8"}, 64'(done8), 64'd1);
    check({tag, "_r1"}, 64'(r1), 64'(e1));
    check({tag, "_r2"}, 64'(r2), 64'(e2));
    check({tag, "_r8"}, 64'(r8), 64'(e8));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_r1"}, 64'(r1), 64'd0);
    check({tag, "_r8"}, 64'(r8), 64'd0);
    check({tag, "_done1"}, 64'(done1), 64'd0);
    check({tag, "_done8"}, 64'(done8), 64'd0);
  endtask

  initial begin
    gen = rand_point();
    pt  = rand_point();
    qt  = rand_point();

    // Run A: identity scalar, P + (-P), random mix with a zero scalar and an O point.
    g1[0] = gen;  x1[0] = SCALAR_WIDTH'(1);
    g2[0] = pt;   g2[1] = neg(pt);
    x2[0] = SCALAR_WIDTH'(1);  x2[1] = SCALAR_WIDTH'(1);
    fill8_random();
    x8[3] = '0;
    g8[5] = '0;
    e1 = gen;
    e2 = '0;
    e8 = model8(g8, x8);
    #2 rst = 1'b1;
    #1 check_cleared("reset_a");
    @(negedge clk) rst = 1'b0;
    wait_all("run_a");
    check_results("run_a");
    repeat (20) @(negedge clk);
    check_results("hold_a");

    // Run B: zero scalar, 2P + 2P (doubling on accumulate), all-ones scalar.
    x1[0] = '0;
    g2[0] = pt;   g2[1] = pt;
    x2[0] = SCALAR_WIDTH'(2);  x2[1] = SCALAR_WIDTH'(2);
    fill8_random();
    x8[6] = '1;
    x8[0] = SCALAR_WIDTH'(1);
    e1 = '0;
    e2 = smul(4, pt);
    e8 = model8(g8, x8);
    rst = 1'b1;
    #1 check_cleared("reset_b");
    @(negedge clk) rst = 1'b0;
    wait_all("run_b");
    check_results("run_b");

    // Run C: 2G, two distinct points, random set; reset halfway then restart.
    x1[0] = SCALAR_WIDTH'(2);
    g2[0] = pt;   g2[1] = qt;
    x2[0] = SCALAR_WIDTH'($urandom);  x2[1] = SCALAR_WIDTH'($urandom);
    fill8_random();
    e1 = padd(gen, gen);
    e2 = padd(smul(64'(x2[0]), pt), smul(64'(x2[1]), qt));
    e8 = model8(g8, x8);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    repeat (1500) @(negedge clk);
    check("mid_done1_before", 64'(done1), 64'd1);
    #2 rst = 1'b1;
    #1 check_cleared("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_all("run_c");
    check_results("run_c");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
